vectored_interrupt_controller: RTL and testbench

Parametrised multi-source interrupt controller for the 5-stage RV32 pipeline. It replaces the single-signal PC override with per-line enable, priority, edge/level mode and threshold, plus vectored dispatch and MRET return.
It sits in IF between the branch-select mux output (PC_NEXT) and the PC register (PC_NEXT_FINAL). It drives a trap pulse that the flush unit uses to clear IF/ID and ID/EX.
Configuration registers are accessed from the zicsr block over a simple synchronous register port.

---
 rtl/vectored_interrupt_controller_pkg.sv | 30 +++
 rtl/vectored_interrupt_controller_if.sv | 17 +
 rtl/vectored_interrupt_controller_irq_priority_arbiter.sv | 60 ++++++
 rtl/vectored_interrupt_controller.sv | 201 ++++++++++++++++++++
 tb/tb_vectored_interrupt_controller.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vectored_interrupt_controller_pkg.sv
// Shared definitions for the vectored interrupt controller.
// Contents: config register indices, FSM state encoding, the MCAUSE
// interrupt flag, and the vector-address helper.
package vectored_interrupt_controller_pkg;

  localparam int unsigned CFG_ADDR_W = 6;
  localparam int unsigned IRQ_ID_W   = 5;

  localparam logic [CFG_ADDR_W-1:0] CFG_ENABLE    = 6'd0;
  localparam logic [CFG_ADDR_W-1:0] CFG_PENDING   = 6'd1;
  localparam logic [CFG_ADDR_W-1:0] CFG_THRESHOLD = 6'd2;
  localparam logic [CFG_ADDR_W-1:0] CFG_STATUS    = 6'd3;
  localparam logic [CFG_ADDR_W-1:0] CFG_MEPC      = 6'd4;
  localparam logic [CFG_ADDR_W-1:0] CFG_MCAUSE    = 6'd5;
  localparam logic [CFG_ADDR_W-1:0] CFG_PRIO_BASE = 6'd8;

  localparam logic [31:0] MCAUSE_IRQ_BIT = 32'h8000_0000;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_ISR = 1'b1
  } vic_state_e;

  // Line i dispatches to base + 4*i.
  function automatic logic [31:0] vec_target(input logic [31:0] base,
                                             input logic [IRQ_ID_W-1:0] id);
    return base + {25'd0, id, 2'b00};
  endfunction

endpackage

// File: rtl/vectored_interrupt_controller_if.sv
// Configuration register port between the zicsr block (master) and the
// interrupt controller (slave).
//   cfg_we    : write strobe, write lands at the next clock edge
//   cfg_addr  : register index
//   cfg_wdata : write data
//   cfg_rdata : combinational read data for cfg_addr
interface vectored_interrupt_controller_if;
  import vectored_interrupt_controller_pkg::*;

  logic                  cfg_we;
  logic [CFG_ADDR_W-1:0] cfg_addr;
  logic [31:0]           cfg_wdata;
  logic [31:0]           cfg_rdata;

  modport master (output cfg_we, cfg_addr, cfg_wdata, input cfg_rdata);
  modport slave  (input cfg_we, cfg_addr, cfg_wdata, output cfg_rdata);
endinterface

// File: rtl/vectored_interrupt_controller_irq_priority_arbiter.sv
// irq_priority_arbiter: binary reduction tree selecting the candidate with
// the highest priority; on equal priority the lower index wins.
// Ports:
//   cand_i  : candidate mask, one bit per line
//   prio_i  : packed priorities, line i at [i*PRIO_W +: PRIO_W]
//   valid_o : at least one candidate present
//   id_o    : index of the winning line (0 when valid_o is low)
module irq_priority_arbiter #(
  parameter int unsigned N      = 8,
  parameter int unsigned PRIO_W = 3,
  parameter int unsigned ID_W   = 5
) (
  input  logic [N-1:0]        cand_i,
  input  logic [N*PRIO_W-1:0] prio_i,
  output logic                valid_o,
  output logic [ID_W-1:0]     id_o
);

  // Leaves padded to a power of two; heap layout, root at 0, leaves last.
  localparam int LEAVES = (N <= 1) ? 1 : (1 << $clog2(N));
  localparam int NODES  = 2 * LEAVES - 1;

  logic              node_valid [NODES];
  logic [PRIO_W-1:0] node_prio  [NODES];
  logic [ID_W-1:0]   node_id    [NODES];

  // Fill leaves, then reduce pairs bottom-up; the left child holds lower indices.
  always_comb begin
    node_valid = '{default: 1'b0};
    node_prio  = '{default: '0};
    node_id    = '{default: '0};
    for (int i = 0; i < LEAVES; i++) begin
      if (i < N) begin
        node_valid[LEAVES-1+i] = cand_i[i];
        node_prio[LEAVES-1+i]  = prio_i[i*PRIO_W +: PRIO_W];
        node_id[LEAVES-1+i]    = ID_W'(i);
      end else begin
        node_valid[LEAVES-1+i] = 1'b0;
        node_prio[LEAVES-1+i]  = '0;
        node_id[LEAVES-1+i]    = '0;
      end
    end
    for (int k = LEAVES - 2; k >= 0; k--) begin
      node_valid[k] = node_valid[2*k+1] | node_valid[2*k+2];
      // Right child only wins with strictly higher priority.
      if (node_valid[2*k+2] &&
          (!node_valid[2*k+1] || (node_prio[2*k+2] > node_prio[2*k+1]))) begin
        node_prio[k] = node_prio[2*k+2];
        node_id[k]   = node_id[2*k+2];
      end else begin
        node_prio[k] = node_prio[2*k+1];
        node_id[k]   = node_id[2*k+1];
      end
    end
  end

  assign valid_o = node_valid[0];
  assign id_o    = node_valid[0] ? node_id[0] : '0;

endmodule

// File: rtl/vectored_interrupt_controller.sv
// Vectored interrupt controller sitting between the IF branch-select mux
// and the PC register. Synchronises the IRQ lines, keeps pending/enable/
// priority/threshold state, dispatches the winning line to its vector and
// returns to MEPC on MRET.
// Ports:
//   CLK, RESET       : clock, synchronous active-high reset
//   irq_i            : asynchronous interrupt request lines
//   pc_next_i        : next PC from branch/hazard muxes
//   stall_i          : PC not advancing this cycle
//   redirect_i       : EX branch/jump redirect active this cycle
//   mret_i           : MRET resolved in EX
//   pc_next_final_o  : PC loaded into the PC register
//   trap_taken_o     : trap dispatched this cycle (flush request)
//   irq_ack_o        : one-hot acknowledge of the dispatched line
//   cfg              : configuration register port (slave)
module vectored_interrupt_controller
  import vectored_interrupt_controller_pkg::*;
#(
  parameter int unsigned          NUM_IRQ   = 8,
  parameter int unsigned          PRIO_W    = 3,
  parameter logic [NUM_IRQ-1:0]   EDGE_MASK = 8'hFF,
  parameter logic [31:0]          VEC_BASE  = 32'h0000_0100
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [NUM_IRQ-1:0]         irq_i,
  input  logic [31:0]                pc_next_i,
  input  logic                       stall_i,
  input  logic                       redirect_i,
  input  logic                       mret_i,
  output logic [31:0]                pc_next_final_o,
  output logic                       trap_taken_o,
  output logic [NUM_IRQ-1:0]         irq_ack_o,
  vectored_interrupt_controller_if.slave cfg
);

  logic [NUM_IRQ-1:0]  sync1_q, sync2_q, prev_q;
  logic [NUM_IRQ-1:0]  enable_q, enable_d, pending_q, pending_d;
  logic [PRIO_W-1:0]   prio_q [NUM_IRQ];
  logic [PRIO_W-1:0]   prio_d [NUM_IRQ];
  logic [PRIO_W-1:0]   threshold_q, threshold_d;
  logic                mie_q, mie_d, saved_mie_q, saved_mie_d;
  logic [31:0]         mepc_q, mepc_d, mcause_q, mcause_d;
  vic_state_e          state_q, state_d;

  logic [NUM_IRQ-1:0]        rise_s, cand_s, ack_s, w1c_s;
  logic [NUM_IRQ*PRIO_W-1:0] prio_flat_s;
  logic [PRIO_W-1:0]         prio_rd_s;
  logic                      arb_valid_s, take_trap_s, do_mret_s;
  logic [IRQ_ID_W-1:0]       arb_id_s;

  assign rise_s = sync2_q & ~prev_q;
  assign w1c_s  = (cfg.cfg_we && (cfg.cfg_addr == CFG_PENDING))
                  ? (cfg.cfg_wdata[NUM_IRQ-1:0] & EDGE_MASK) : '0;

  // Candidate mask, flattened priorities, ack decode and priority read-back.
  always_comb begin
    cand_s      = '0;
    ack_s       = '0;
    prio_flat_s = '0;
    prio_rd_s   = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      cand_s[i] = pending_q[i] & enable_q[i] & (prio_q[i] > threshold_q);
      ack_s[i]  = (arb_id_s == IRQ_ID_W'(i));
      prio_flat_s[i*PRIO_W +: PRIO_W] = prio_q[i];
      prio_rd_s = prio_rd_s |
                  (prio_q[i] & {PRIO_W{cfg.cfg_addr == (CFG_PRIO_BASE + 6'(i))}});
    end
  end

  irq_priority_arbiter #(
    .N      (NUM_IRQ),
    .PRIO_W (PRIO_W),
    .ID_W   (IRQ_ID_W)
  ) u_arb (
    .cand_i  (cand_s),
    .prio_i  (prio_flat_s),
    .valid_o (arb_valid_s),
    .id_o    (arb_id_s)
  );

  assign take_trap_s = (state_q == ST_IDLE) && arb_valid_s && mie_q &&
                       !stall_i && !redirect_i;
  assign do_mret_s   = (state_q == ST_IN_ISR) && mret_i && !stall_i;

  // PC override, trap pulse and acknowledge for the current cycle.
  always_comb begin
    pc_next_final_o = pc_next_i;
    trap_taken_o    = 1'b0;
    irq_ack_o       = '0;
    if (take_trap_s) begin
      pc_next_final_o = vec_target(VEC_BASE, arb_id_s);
      trap_taken_o    = 1'b1;
      irq_ack_o       = ack_s;
    end else if (do_mret_s) begin
      pc_next_final_o = mepc_q;
    end else begin
      pc_next_final_o = pc_next_i;
    end
  end

  // Config reads; unmapped indices return zero.
  always_comb begin
    cfg.cfg_rdata = 32'd0;
    case (cfg.cfg_addr)
      CFG_ENABLE:    cfg.cfg_rdata = 32'(enable_q);
      CFG_PENDING:   cfg.cfg_rdata = 32'(pending_q);
      CFG_THRESHOLD: cfg.cfg_rdata = 32'(threshold_q);
      CFG_STATUS:    cfg.cfg_rdata = {30'd0, (state_q == ST_IN_ISR), mie_q};
      CFG_MEPC:      cfg.cfg_rdata = mepc_q;
      CFG_MCAUSE:    cfg.cfg_rdata = mcause_q;
      default:       cfg.cfg_rdata = 32'(prio_rd_s);
    endcase
  end

  // Next-state: config writes first, then trap/MRET effects override them.
  always_comb begin
    state_d     = state_q;
    enable_d    = enable_q;
    threshold_d = threshold_q;
    mie_d       = mie_q;
    saved_mie_d = saved_mie_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    pending_d   = pending_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      prio_d[i] = (cfg.cfg_we && (cfg.cfg_addr == (CFG_PRIO_BASE + 6'(i))))
                  ? cfg.cfg_wdata[PRIO_W-1:0] : prio_q[i];
    end

    if (cfg.cfg_we) begin
      case (cfg.cfg_addr)
        CFG_ENABLE:    enable_d    = cfg.cfg_wdata[NUM_IRQ-1:0];
        CFG_THRESHOLD: threshold_d = cfg.cfg_wdata[PRIO_W-1:0];
        CFG_STATUS:    mie_d       = cfg.cfg_wdata[0];
        CFG_MEPC:      mepc_d      = cfg.cfg_wdata;
        default:       mepc_d      = mepc_q;
      endcase
    end else begin
      mepc_d = mepc_q;
    end

    if (take_trap_s) begin
      state_d     = ST_IN_ISR;
      mepc_d      = pc_next_i;
      mcause_d    = MCAUSE_IRQ_BIT | 32'(arb_id_s);
      saved_mie_d = mie_q;
      mie_d       = 1'b0;
    end else if (do_mret_s) begin
      state_d = ST_IDLE;
      mie_d   = saved_mie_q;
    end else begin
      state_d = state_q;
    end

    // Edge lines: a new edge beats any clear in the same cycle.
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (!EDGE_MASK[i]) begin
        pending_d[i] = sync2_q[i];
      end else if (rise_s[i]) begin
        pending_d[i] = 1'b1;
      end else if (w1c_s[i] || (take_trap_s && ack_s[i])) begin
        pending_d[i] = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      enable_q    <= '0;
      pending_q   <= '0;
      threshold_q <= '0;
      mie_q       <= 1'b0;
      saved_mie_q <= 1'b0;
      mepc_q      <= 32'd0;
      mcause_q    <= 32'd0;
      state_q     <= ST_IDLE;
      for (int i = 0; i < NUM_IRQ; i++) prio_q[i] <= '0;
    end else begin
      sync1_q     <= irq_i;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      enable_q    <= enable_d;
      pending_q   <= pending_d;
      threshold_q <= threshold_d;
      mie_q       <= mie_d;
      saved_mie_q <= saved_mie_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
      state_q     <= state_d;
      for (int i = 0; i < NUM_IRQ; i++) prio_q[i] <= prio_d[i];
    end
  end

endmodule

// File: tb/tb_vectored_interrupt_controller.sv
// Directed testbench for vectored_interrupt_controller. Line 7 is built as
// a level line, lines 0..6 as edge lines.
module tb_vectored_interrupt_controller;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  irq;
  logic [31:0] pc_next;
  logic        stall, redirect, mret;
  logic [31:0] pc_next_final;
  logic        trap_taken;
  logic [7:0]  irq_ack;

  int n_checks = 0;
  int n_errors = 0;

  vectored_interrupt_controller_if cfg_bus ();

  vectored_interrupt_controller #(
    .NUM_IRQ   (8),
    .PRIO_W    (3),
    .EDGE_MASK (8'h7F),
    .VEC_BASE  (32'h0000_0100)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .irq_i           (irq),
    .pc_next_i       (pc_next),
    .stall_i         (stall),
    .redirect_i      (redirect),
    .mret_i          (mret),
    .pc_next_final_o (pc_next_final),
    .trap_taken_o    (trap_taken),
    .irq_ack_o       (irq_ack),
    .cfg             (cfg_bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg_write(input logic [5:0] addr, input logic [31:0] data);
    cfg_bus.cfg_we    = 1'b1;
    cfg_bus.cfg_addr  = addr;
    cfg_bus.cfg_wdata = data;
    tick();
    cfg_bus.cfg_we    = 1'b0;
    cfg_bus.cfg_wdata = 32'd0;
  endtask

  task automatic cfg_check(input string tag, input logic [5:0] addr, input logic [31:0] exp);
    cfg_bus.cfg_addr = addr;
    #1;
    check(tag, cfg_bus.cfg_rdata, exp);
  endtask

  // One-cycle pin pulse, then wait until pending is visible.
  task automatic pulse_irq(input logic [7:0] mask);
    irq = mask;
    tick();
    irq = 8'h00;
    tick();
    tick();
  endtask

  task automatic check_trap(input string tag, input logic [31:0] pc, input logic [7:0] ack);
    #1;
    check({tag, "_trap"}, {31'd0, trap_taken}, 32'd1);
    check({tag, "_pc"}, pc_next_final, pc);
    check({tag, "_ack"}, {24'd0, irq_ack}, {24'd0, ack});
  endtask

  task automatic check_no_trap(input string tag);
    #1;
    check({tag, "_trap"}, {31'd0, trap_taken}, 32'd0);
    check({tag, "_pc"}, pc_next_final, pc_next);
  endtask

  // MRET from a handler entered at PC 0x40.
  task automatic do_mret(input string tag);
    mret    = 1'b1;
    pc_next = 32'h0000_0080;
    #1;
    check({tag, "_mret_pc"}, pc_next_final, 32'h0000_0040);
    tick();
    mret    = 1'b0;
    pc_next = 32'h0000_0040;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; irq = 8'h00; pc_next = 32'h0000_0040;
    stall = 1'b0; redirect = 1'b0; mret = 1'b0;
    cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_addr = 6'd0; cfg_bus.cfg_wdata = 32'd0;
    tick(); tick();
    RESET = 1'b0;

    // Reset state
    check_no_trap("rst");
    cfg_check("rst_enable", 6'd0, 32'd0);
    cfg_check("rst_status", 6'd3, 32'd0);
    cfg_check("rst_mcause", 6'd5, 32'd0);

    // Basic dispatch; concurrent MIE write in the trap cycle loses
    cfg_write(6'd0, 32'h01);
    cfg_write(6'd8, 32'd1);
    cfg_write(6'd3, 32'd1);
    pulse_irq(8'h01);
    check_trap("t1", 32'h0000_0100, 8'h01);
    cfg_write(6'd3, 32'd1);
    check_no_trap("t1_after");
    cfg_check("t1_mepc", 6'd4, 32'h0000_0040);
    cfg_check("t1_mcause", 6'd5, 32'h8000_0000);
    cfg_check("t1_status", 6'd3, 32'h2);
    cfg_check("t1_pending", 6'd1, 32'h0);
    do_mret("t1");
    cfg_check("t1_status_ret", 6'd3, 32'h1);

    // Equal priority: lowest index wins, the other follows after MRET
    cfg_write(6'd10, 32'd3);
    cfg_write(6'd13, 32'd3);
    cfg_write(6'd0, 32'h24);
    pulse_irq(8'h24);
    check_trap("t2a", 32'h0000_0108, 8'h04);
    tick();
    cfg_check("t2a_pending", 6'd1, 32'h20);
    do_mret("t2a");
    check_trap("t2a_next", 32'h0000_0114, 8'h20);
    tick();
    do_mret("t2a_next");

    // Higher priority on line 5 wins
    cfg_write(6'd13, 32'd6);
    pulse_irq(8'h24);
    check_trap("t2b", 32'h0000_0114, 8'h20);
    tick();
    do_mret("t2b");
    check_trap("t2b_next", 32'h0000_0108, 8'h04);
    tick();
    do_mret("t2b_next");

    // Threshold masks equal priority until lowered
    cfg_write(6'd0, 32'h02);
    cfg_write(6'd9, 32'd3);
    cfg_write(6'd2, 32'd3);
    pulse_irq(8'h02);
    check_no_trap("t3_masked");
    cfg_write(6'd2, 32'd2);
    check_trap("t3", 32'h0000_0104, 8'h02);
    tick();
    do_mret("t3");

    // Deferral under STALL and REDIRECT
    cfg_write(6'd2, 32'd0);
    cfg_write(6'd0, 32'h01);
    stall = 1'b1;
    pulse_irq(8'h01);
    cfg_check("t4_pending", 6'd1, 32'h01);
    for (int i = 0; i < 4; i++) begin
      check_no_trap("t4_stall");
      tick();
    end
    stall = 1'b0; redirect = 1'b1;
    check_no_trap("t4_redirect");
    tick();
    redirect = 1'b0;
    check_trap("t4", 32'h0000_0100, 8'h01);
    tick();
    cfg_check("t4_pending_clr", 6'd1, 32'h0);
    do_mret("t4");

    // No nesting; MRET with a same-cycle MEPC write uses the old MEPC
    cfg_write(6'd0, 32'h09);
    cfg_write(6'd11, 32'd2);
    pulse_irq(8'h01);
    check_trap("t5_outer", 32'h0000_0100, 8'h01);
    tick();
    pulse_irq(8'h08);
    check_no_trap("t5_nested");
    cfg_check("t5_pending", 6'd1, 32'h08);
    cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_addr = 6'd4; cfg_bus.cfg_wdata = 32'h0000_0200;
    do_mret("t5");
    cfg_bus.cfg_we = 1'b0;
    check_trap("t5_inner", 32'h0000_010C, 8'h08);
    cfg_check("t5_mepc_wr", 6'd4, 32'h0000_0200);
    cfg_check("t5_status", 6'd3, 32'h1);
    tick();
    do_mret("t5_inner");

    // Level line 7: mirrors pin, not cleared by trap or W1C
    cfg_write(6'd0, 32'h80);
    cfg_write(6'd15, 32'd4);
    irq = 8'h80;
    tick(); tick(); tick();
    cfg_check("t6_pending", 6'd1, 32'h80);
    check_trap("t6", 32'h0000_011C, 8'h80);
    tick();
    cfg_write(6'd1, 32'h80);
    cfg_check("t6_w1c_ign", 6'd1, 32'h80);
    irq = 8'h00;
    tick(); tick(); tick();
    cfg_check("t6_pending_low", 6'd1, 32'h0);
    do_mret("t6");
    check_no_trap("t6_after");

    // W1C same cycle as new edge: set wins; plain W1C clears
    cfg_write(6'd0, 32'h00);
    irq = 8'h10;
    tick();
    irq = 8'h00;
    tick();
    cfg_write(6'd1, 32'h10);
    cfg_check("t7_set_wins", 6'd1, 32'h10);
    cfg_write(6'd1, 32'h10);
    cfg_check("t7_w1c", 6'd1, 32'h0);

    // Unmapped addresses
    cfg_write(6'd6, 32'hFFFF_FFFF);
    cfg_check("unmapped6", 6'd6, 32'h0);
    cfg_check("unmapped20", 6'd20, 32'h0);

    // Reset in the middle of a handler with pending bits
    cfg_write(6'd0, 32'h01);
    pulse_irq(8'h01);
    check_trap("t8", 32'h0000_0100, 8'h01);
    tick();
    pulse_irq(8'h10);
    cfg_check("t8_pending", 6'd1, 32'h10);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    pc_next = 32'h0000_0123;
    check_no_trap("t8_rst");
    cfg_check("t8_status", 6'd3, 32'h0);
    cfg_check("t8_pend", 6'd1, 32'h0);
    cfg_check("t8_enable", 6'd0, 32'h0);
    cfg_check("t8_mepc", 6'd4, 32'h0);
    cfg_check("t8_mcause", 6'd5, 32'h0);
    cfg_check("t8_prio0", 6'd8, 32'h0);
    cfg_check("t8_thresh", 6'd2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
